// File: rtl/mc_core_seq.sv
// Multi-cycle fetch/execute/memory/writeback sequencer with a timeout guard on every handshake wait.
// Define MC_CORE_SEQ_PERF_EN to add the cycle_cnt_o/instret_o performance counters.
module mc_core_seq #(
   parameter int              XLEN     = 32,
   parameter logic [XLEN-1:0] RESET_PC = 32'h8000_0000,
   parameter int              TMO_W    = 8
) (
   input  logic            clk_i,
   input  logic            rst_i,
   output logic            imem_req_o,
   output logic [XLEN-1:0] imem_addr_o,
   input  logic            imem_gnt_i,
   input  logic            imem_rvalid_i,
   input  logic [31:0]     imem_rdata_i,
   output logic [31:0]     inst_o,
   input  logic            is_load_i,
   input  logic            is_store_i,
   input  logic            is_ebreak_i,
   input  logic [XLEN-1:0] next_pc_i,
   output logic            dmem_req_o,
   output logic            dmem_we_o,
   input  logic            dmem_gnt_i,
   input  logic            dmem_rvalid_i,
   output logic            wen_reg_o,
   output logic            retire_o,
   output logic [XLEN-1:0] pc_o,
   output logic            halt_o,
   output logic            err_o
`ifdef MC_CORE_SEQ_PERF_EN
   ,
   output logic [63:0]     cycle_cnt_o,
   output logic [63:0]     instret_o
`endif
);

   typedef enum logic [2:0] {
      FETCH_REQ, FETCH_WAIT, EXEC, MEM_REQ, MEM_WAIT, WB, HALT, ERR
   } state_e;

   localparam logic [TMO_W-1:0] TMO_MAX  = '1;
   localparam logic [TMO_W-1:0] TMO_LAST = TMO_MAX - 1'b1;
   localparam logic [31:0]      NOP_INST = 32'h0000_0013;

   state_e            state_q, state_d;
   logic [XLEN-1:0]   pc_q, pc_d;
   logic [31:0]       inst_q, inst_d;
   logic [TMO_W-1:0]  tmo_q, tmo_d;
   logic              wen_q, wen_d;
   logic              retire_q, retire_d;
   logic              halt_q, halt_d;
   logic              err_q, err_d;
   logic              waiting;

   always_comb begin
      state_d  = state_q;
      pc_d     = pc_q;
      inst_d   = inst_q;
      tmo_d    = tmo_q;
      wen_d    = 1'b0;
      retire_d = 1'b0;
      halt_d   = halt_q;
      err_d    = err_q;
      waiting  = (state_q == FETCH_REQ) || (state_q == FETCH_WAIT) ||
                 (state_q == MEM_REQ)   || (state_q == MEM_WAIT);

      case (state_q)
         FETCH_REQ: begin
            if (imem_gnt_i) begin
               if (imem_rvalid_i) begin
                  inst_d  = imem_rdata_i;
                  state_d = EXEC;
               end else begin
                  state_d = FETCH_WAIT;
               end
            end
         end
         FETCH_WAIT: begin
            if (imem_rvalid_i) begin
               inst_d  = imem_rdata_i;
               state_d = EXEC;
            end
         end
         EXEC: begin
            if (is_ebreak_i) begin
               state_d  = HALT;
               halt_d   = 1'b1;
               retire_d = 1'b1;
            end else if (is_load_i || is_store_i) begin
               state_d = MEM_REQ;
            end else begin
               state_d = WB;
            end
         end
         MEM_REQ: begin
            if (dmem_gnt_i) begin
               state_d = dmem_rvalid_i ? WB : MEM_WAIT;
            end
         end
         MEM_WAIT: begin
            if (dmem_rvalid_i) begin
               state_d = WB;
            end
         end
         WB: begin
            pc_d    = next_pc_i;
            state_d = FETCH_REQ;
         end
         default: state_d = state_q;
      endcase

      // A stalled handshake that reaches its last allowed wait cycle diverts to ERR instead.
      if (state_d != state_q) begin
         tmo_d = '0;
      end else if (waiting) begin
         if (tmo_q == TMO_LAST) begin
            state_d = ERR;
            err_d   = 1'b1;
            tmo_d   = TMO_MAX;
         end else if (tmo_q != TMO_MAX) begin
            tmo_d = tmo_q + 1'b1;
         end
      end

      if (state_d == WB) begin
         wen_d    = !is_store_i;
         retire_d = 1'b1;
      end
   end

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         state_q  <= FETCH_REQ;
         pc_q     <= RESET_PC;
         inst_q   <= NOP_INST;
         tmo_q    <= '0;
         wen_q    <= 1'b0;
         retire_q <= 1'b0;
         halt_q   <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         pc_q     <= pc_d;
         inst_q   <= inst_d;
         tmo_q    <= tmo_d;
         wen_q    <= wen_d;
         retire_q <= retire_d;
         halt_q   <= halt_d;
         err_q    <= err_d;
      end
   end

   assign imem_req_o  = (state_q == FETCH_REQ);
   assign imem_addr_o = pc_q;
   assign dmem_req_o  = (state_q == MEM_REQ);
   assign dmem_we_o   = (state_q == MEM_REQ) && is_store_i;
   assign inst_o      = inst_q;
   assign pc_o        = pc_q;
   assign wen_reg_o   = wen_q;
   assign retire_o    = retire_q;
   assign halt_o      = halt_q;
   assign err_o       = err_q;

`ifdef MC_CORE_SEQ_PERF_EN
   logic [63:0] cycle_q, cycle_d;
   logic [63:0] instret_q, instret_d;

   always_comb begin
      cycle_d   = cycle_q;
      instret_d = instret_q;
      if ((state_q != HALT) && (state_q != ERR)) begin
         cycle_d = cycle_q + 64'd1;
      end
      if (retire_q) begin
         instret_d = instret_q + 64'd1;
      end
   end

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         cycle_q   <= '0;
         instret_q <= '0;
      end else begin
         cycle_q   <= cycle_d;
         instret_q <= instret_d;
      end
   end

   assign cycle_cnt_o = cycle_q;
   assign instret_o   = instret_q;
`endif

endmodule
